// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-and-add sequencer producing the low 32 bits of a 32x32 multiply on a shared ALU.
// Optional macro MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module alu_mul_seq (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [31:0] i_op_a,
  input  logic [31:0] i_op_b,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_product,
  output logic [31:0] o_alu_a,
  output logic [31:0] o_alu_b,
  output logic [3:0]  o_alu_op,
  input  logic [31:0] i_alu_result,
  input  logic        i_alu_zero
);

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b1101;
  localparam logic [3:0] OP_SRL = 4'b1110;

`ifdef MUL_EARLY_EXIT_EN
  localparam bit EarlyExit = 1'b1;
`else
  localparam bit EarlyExit = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_ADD, S_SHL, S_SHR, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_acc;
  logic [31:0] r_mc;
  logic [31:0] r_mp;
  logic [31:0] r_product;
  logic [4:0]  r_cnt;
  logic        w_last;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    o_alu_a  = '0;
    o_alu_b  = '0;
    o_alu_op = 4'b0000;
    w_last   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (EarlyExit && (i_op_b == '0)) w_next = S_DONE;
          else if (i_op_b[0])             w_next = S_ADD;
          else                            w_next = S_SHL;
        end
      end
      S_ADD: begin
        o_alu_a  = r_acc;
        o_alu_b  = r_mc;
        o_alu_op = OP_ADD;
        w_next   = S_SHL;
      end
      S_SHL: begin
        o_alu_a  = r_mc;
        o_alu_b  = 32'd1;
        o_alu_op = OP_SLL;
        w_next   = S_SHR;
      end
      S_SHR: begin
        o_alu_a  = r_mp;
        o_alu_b  = 32'd1;
        o_alu_op = OP_SRL;
        // The shifted multiplier's new LSB decides whether the next iteration adds.
        w_last   = (r_cnt == 5'd31) || (EarlyExit && i_alu_zero);
        if (w_last)               w_next = S_DONE;
        else if (i_alu_result[0]) w_next = S_ADD;
        else                      w_next = S_SHL;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_acc     <= '0;
      r_mc      <= '0;
      r_mp      <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_acc <= '0;
            r_mc  <= i_op_a;
            r_mp  <= i_op_b;
            r_cnt <= '0;
          end
        end
        S_ADD: r_acc <= i_alu_result;
        S_SHL: r_mc  <= i_alu_result;
        S_SHR: begin
          r_mp  <= i_alu_result;
          r_cnt <= r_cnt + 5'd1;
        end
        S_DONE:  r_product <= r_acc;
        default: ;
      endcase
    end
  end

  assign o_busy    = (r_state == S_ADD) || (r_state == S_SHL) || (r_state == S_SHR);
  assign o_done    = (r_state == S_DONE);
  assign o_product = r_product;

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle sequencer that computes the low 32 bits of a 32x32 multiply (RV32 MUL) by driving the shared 32-bit ALU through add / shift-left / shift-right steps. It sits beside the execute stage and borrows the ALU while busy. It owns the ALU's operand and opcode inputs through an external mux, and consumes the ALU's result and zero flag. It holds accumulator, multiplicand, multiplier and iteration count, and returns the product with a one-cycle done pulse.

## Interface
- OP_ADD, 4'b0010, ALU opcode for add
- OP_SLL, 4'b1101, ALU opcode for logical shift left
- OP_SRL, 4'b1110, ALU opcode for logical shift right
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  request; sampled only in IDLE
- op_a  in  32  multiplicand, captured on accepted start
- op_b  in  32  multiplier, captured on accepted start
- busy  out  1  high in ADD/SHL/SHR
- done  out  1  one-cycle pulse in DONE
- product  out  32  low 32 bits of op_a*op_b; held until next accepted start
- alu_a  out  32  ALU operand A (combinational from state)
- alu_b  out  32  ALU operand B (combinational from state)
- alu_op  out  4  ALU opcode (combinational from state)
- alu_result  in  32  ALU result
- alu_zero  in  1  ALU zero flag (alu_result==0)

## Operation
- Registers: acc[31:0], mc[31:0], mp[31:0], cnt[4:0], state, product[31:0].
- Reset values: state IDLE; acc, mc, mp, cnt and product are 0; busy=0, done=0; alu_a=0, alu_b=0, alu_op=4'b0000.
- IDLE: ALU outputs are 0/0/4'b0000. If start=1:
  - acc<=0, mc<=op_a, mp<=op_b, cnt<=0.
  - Next state is ADD if op_b[0]=1, else SHL.
  - Early-exit case (see Configuration): if op_b==0, next state is DONE.
- ADD: alu_a=acc, alu_b=mc, alu_op=OP_ADD. Update acc<=alu_result. Next state SHL.
- SHL: alu_a=mc, alu_b=1, alu_op=OP_SLL. Update mc<=alu_result. Next state SHR.
- SHR: alu_a=mp, alu_b=1, alu_op=OP_SRL. Update mp<=alu_result and cnt<=cnt+1.
  - Go to DONE if cnt==31, or if early exit is enabled and alu_zero=1.
  - Otherwise, go to ADD if alu_result[0]=1, else SHL.
- DONE: done=1, product<=acc (the accumulator is already final). Next state IDLE.
- Arithmetic is modulo 2^32. Overflow is discarded silently. Sign-agnostic, because the low word is the same for signed and unsigned operands.
- start is ignored outside IDLE, including in the DONE cycle. op_a and op_b are don't-care after capture.
- Reset asserted mid-operation: immediate return to IDLE with reset values. No done pulse. product is cleared to 0.

## Timing
- Start is accepted on edge T0. Each multiplier bit i costs 2+b_i cycles (ADD only when the bit is set).
- Early exit enabled: done is high in cycle T0+1+Σ_{i=0..k}(2+b_i), where k is the index of the highest set bit of op_b.
- op_b==0 with early exit enabled: done is high in cycle T0+1.
- Early exit disabled: always 32 iterations. done is high in cycle T0+1+64+popcount(op_b).
- product updates on the edge that ends DONE. It is valid from the cycle after the done pulse.
- busy and done are never high together. busy is high for every ADD/SHL/SHR cycle.
- The next start can be accepted in the cycle after DONE, i.e. back-to-back with one IDLE cycle.

## Configuration
- MUL_EARLY_EXIT_EN defined: the sequence terminates when the shifted multiplier becomes zero (alu_zero in SHR), or at cnt==31. op_b==0 goes straight from IDLE to DONE.
- MUL_EARLY_EXIT_EN undefined: the zero flag is ignored. Every operation runs exactly 32 iterations, giving a data-independent latency except for ADD cycles. op_b==0 takes 64 busy cycles.

## Test plan
- Early exit on, op_a=3, op_b=5 -> ALU op sequence ADD,SHL,SHR,SHL,SHR,ADD,SHL,SHR; done in cycle T0+9; product=15.
- Early exit on, op_a=0x1234, op_b=0 -> no busy cycles; done in cycle T0+1; product=0.
- op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> product=0x00000001.
  - Early exit on: done in cycle T0+97.
  - Early exit off: done in cycle T0+97.
- op_a=0x80000000, op_b=2 -> product=0x00000000 (wrap). Early exit off: done in cycle T0+66.
- Assert start every cycle during an operation with changing op_a/op_b -> ignored; result matches the first captured operands; next start accepted only after DONE.
- Assert reset at the 5th busy cycle of 7*9 -> busy=0, done=0, product=0, ALU outputs 0 asynchronously. A fresh start of 7*9 afterwards gives product=63.
